result_packer: RTL and testbench

- Receiving end of the add/mul block's west/north output stream. That stream is valid-only, 128-bit wide, and carries the 32-bit result replicated in all four lanes.
- This block takes lane [127:96] of each valid beat and packs 4 consecutive results into one dense 128-bit word.
- It buffers packed words in a small FIFO and presents them downstream on a valid/ready interface, with a last flag at the end of each stage.
- It sits between an array block's output and the stage writeback/memory path.

---
 rtl/glut_pkg.sv | 20 ++
 rtl/result_packer_fifo.sv | 70 +++++++
 rtl/result_packer.sv | 130 +++++++++++++
 tb/tb_result_packer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/glut_pkg.sv
// Shared types for the add/mul result path: lane geometry, packer states, FIFO entry layout.
package glut_pkg;

    localparam int unsigned LANE_W = 32;
    localparam int unsigned BUS_W  = 128;
    localparam int unsigned LANES  = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } pack_state_e;

    typedef struct packed {
        logic             last;
        logic [BUS_W-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/result_packer_fifo.sv
// First-word-fall-through FIFO; the head entry is held in a register so the output is flop-driven.
module result_fifo
    import glut_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        pop,
    input  fifo_entry_t wdata,
    output fifo_entry_t rdata,
    output logic        valid,
    output logic        full,
    output logic        empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    fifo_entry_t    mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic [CW-1:0]  count_next;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && valid;
    // A push into a full FIFO still lands when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_comb begin
        count_next = count + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= 1'b0;
            rdata  <= '0;
        end else begin
            count <= count_next;
            valid <= (count_next != '0);
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            // Head register: bypass the write data when it becomes the new head.
            if (do_push && ((count == '0) || (do_pop && (count == CW'(1))))) begin
                rdata <= wdata;
            end else if (do_pop && (count > CW'(1))) begin
                rdata <= mem[rd_ptr + AW'(1)];
            end
        end
    end

endmodule

// File: rtl/result_packer.sv
// Packs lane [127:96] of consecutive result beats four-per-word and streams them out with a stage-end last flag.
module result_packer
    import glut_pkg::*;
#(
    parameter int unsigned DATA_NUM   = 192,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned CNT_W      = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stage_start,
    input  logic             in_tvalid,
    input  logic [BUS_W-1:0] in_tdata,
    output logic             m_tvalid,
    output logic [BUS_W-1:0] m_tdata,
    output logic             m_tlast,
    input  logic             m_tready,
    output logic [CNT_W-1:0] word_cnt,
    output logic             stage_done,
    output logic             overflow
);

    pack_state_e      state;
    pack_state_e      state_next;
    logic             start_q;
    logic             start_rise;
    logic [1:0]       lane_idx;
    logic [BUS_W-1:0] pack;
    logic [BUS_W-1:0] pack_next;
    logic             accept;
    logic             is_final;
    logic             push_req;
    logic             pop;
    logic             drop;
    logic             fifo_full;
    logic             fifo_empty;
    fifo_entry_t      fifo_in;
    fifo_entry_t      fifo_out;
    logic             unused_lanes;

    assign unused_lanes = ^in_tdata[BUS_W-LANE_W-1:0];
    assign start_rise   = stage_start && !start_q;
    assign pop          = m_tvalid && m_tready;
    assign drop         = push_req && fifo_full && !pop;
    assign fifo_in      = '{last: is_final, data: pack_next};
    assign m_tdata      = fifo_out.data;
    assign m_tlast      = fifo_out.last;

    // Next state, accept/push decode and the pack word including the current beat.
    always_comb begin
        state_next = state;
        pack_next  = pack;
        accept     = (state == COLLECT) && stage_start && in_tvalid;
        is_final   = accept && (word_cnt == CNT_W'(DATA_NUM - 1));
        push_req   = accept && ((lane_idx == 2'(LANES - 1)) || is_final);

        for (int i = 0; i < int'(LANES); i++) begin
            if (lane_idx == 2'(int'(LANES) - 1 - i)) begin
                pack_next[i*LANE_W +: LANE_W] = in_tdata[BUS_W-1 -: LANE_W];
            end
        end

        case (state)
            IDLE:    if (start_rise) state_next = COLLECT;
            COLLECT: if (!stage_start || is_final) state_next = DRAIN;
            DRAIN:   if (fifo_empty && !m_tvalid) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_q    <= 1'b0;
            lane_idx   <= '0;
            pack       <= '0;
            word_cnt   <= '0;
            overflow   <= 1'b0;
            stage_done <= 1'b0;
        end else begin
            start_q    <= stage_start;
            stage_done <= (state_next == DONE);
            if ((state == IDLE) && start_rise) begin
                lane_idx <= '0;
                pack     <= '0;
                word_cnt <= '0;
                overflow <= 1'b0;
            end else begin
                if (accept) begin
                    lane_idx <= lane_idx + 2'd1;
                    pack     <= push_req ? '0 : pack_next;
                    if (word_cnt < CNT_W'(DATA_NUM)) begin
                        word_cnt <= word_cnt + CNT_W'(1);
                    end
                end
                // Abort: the partial group is thrown away, never pushed.
                if ((state == COLLECT) && !stage_start) begin
                    lane_idx <= '0;
                    pack     <= '0;
                end
                if (drop) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

    result_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .pop   (pop),
        .wdata (fifo_in),
        .rdata (fifo_out),
        .valid (m_tvalid),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_result_packer.sv
// Bench for result_packer: directed stage scenarios plus randomized traffic against a queue-based reference.
module tb_result_packer;

    localparam int unsigned N     = 10;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned CW    = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          stage_start;
    logic          in_tvalid;
    logic [127:0]  in_tdata;
    logic          m_tvalid;
    logic [127:0]  m_tdata;
    logic          m_tlast;
    logic          m_tready;
    logic [CW-1:0] word_cnt;
    logic          stage_done;
    logic          overflow;

    always #5 clk = ~clk;

    result_packer #(
        .DATA_NUM   (N),
        .FIFO_DEPTH (DEPTH),
        .CNT_W      (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stage_start (stage_start),
        .in_tvalid   (in_tvalid),
        .in_tdata    (in_tdata),
        .m_tvalid    (m_tvalid),
        .m_tdata     (m_tdata),
        .m_tlast     (m_tlast),
        .m_tready    (m_tready),
        .word_cnt    (word_cnt),
        .stage_done  (stage_done),
        .overflow    (overflow)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [128:0] obs, input logic [128:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Reference: phase 0 idle, 1 collect, 2 drain, 3 done; q holds {last,data} words.
    int           ph;
    logic         prev_st;
    int           cnt;
    logic [31:0]  grp[$];
    logic [128:0] q[$];
    logic         ovf;
    logic [128:0] dut_log[$];
    int           done_pulses;

    task automatic model_reset();
        ph = 0; prev_st = 1'b0; cnt = 0; ovf = 1'b0;
        grp.delete(); q.delete();
    endtask

    task automatic model_step(input logic st, input logic tv, input logic [31:0] v, input logic rdy);
        logic         pop;
        logic         push;
        logic [128:0] w;
        int           sz;
        sz   = q.size();
        pop  = (sz > 0) && rdy;
        push = 1'b0;
        w    = '0;
        if (ph == 1 && st && tv) begin
            grp.push_back(v);
            cnt++;
            if (grp.size() == 4 || cnt == int'(N)) begin
                foreach (grp[i]) w[96 - 32*i +: 32] = grp[i];
                w[128] = (cnt == int'(N));
                push = 1'b1;
                grp.delete();
            end
        end
        if (pop) void'(q.pop_front());
        if (push) begin
            if (sz < int'(DEPTH) || pop) q.push_back(w);
            else ovf = 1'b1;
        end
        case (ph)
            0: if (st && !prev_st) begin ph = 1; cnt = 0; grp.delete(); ovf = 1'b0; end
            1: if (!st) begin ph = 2; grp.delete(); end
               else if (cnt == int'(N)) ph = 2;
            2: if (sz == 0) ph = 3;
            default: ph = 0;
        endcase
        prev_st = st;
    endtask

    task automatic step(input logic st, input logic tv, input logic [31:0] v, input logic rdy);
        @(negedge clk);
        stage_start = st;
        in_tvalid   = tv;
        in_tdata    = {4{v}};
        m_tready    = rdy;
        if (m_tvalid && rdy) dut_log.push_back({m_tlast, m_tdata});
        model_step(st, tv, v, rdy);
        @(posedge clk);
        #1;
        check_eq("m_tvalid", 129'(m_tvalid), 129'(q.size() > 0));
        if (q.size() > 0) check_eq("m_word", {m_tlast, m_tdata}, q[0]);
        check_eq("word_cnt", 129'(word_cnt), 129'(cnt));
        check_eq("stage_done", 129'(stage_done), 129'(ph == 3));
        check_eq("overflow", 129'(overflow), 129'(ovf));
        if (stage_done) done_pulses++;
    endtask

    task automatic check_zero_outputs(input string tag);
        check_eq({tag, "_valid"}, 129'(m_tvalid), '0);
        check_eq({tag, "_data"}, {m_tlast, m_tdata}, '0);
        check_eq({tag, "_cnt"}, 129'(word_cnt), '0);
        check_eq({tag, "_done"}, 129'(stage_done), '0);
        check_eq({tag, "_ovf"}, 129'(overflow), '0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        stage_start = 1'b0;
        in_tvalid   = 1'b0;
        rst         = 1'b1;
        #1;
        check_zero_outputs("rst_mid");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic st, tv, rdy;
        rst = 1'b1; stage_start = 1'b0; in_tvalid = 1'b0; in_tdata = '0; m_tready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Full stage, no backpressure: 1..10 -> two full words and a padded last word.
        dut_log.delete(); done_pulses = 0;
        step(1, 0, 0, 1);
        for (int i = 1; i <= 10; i++) begin
            step(1, 1, 32'(i), 1);
            if (i == 3) check_eq("lat_before", 129'(m_tvalid), 129'(0));
            if (i == 4) check_eq("lat_after", 129'(m_tvalid), 129'(1));
        end
        repeat (6) step(1, 0, 0, 1);
        check_eq("full_nwords", 129'(dut_log.size()), 129'(3));
        if (dut_log.size() == 3) begin
            check_eq("full_w0", dut_log[0], {1'b0, 32'h1, 32'h2, 32'h3, 32'h4});
            check_eq("full_w1", dut_log[1], {1'b0, 32'h5, 32'h6, 32'h7, 32'h8});
            check_eq("full_w2", dut_log[2], {1'b1, 32'h9, 32'hA, 32'h0, 32'h0});
        end
        check_eq("full_cnt", 129'(word_cnt), 129'(10));
        check_eq("full_done_pulses", 129'(done_pulses), 129'(1));
        repeat (2) step(0, 0, 0, 1);

        // Beats outside a stage are ignored.
        repeat (3) step(0, 1, 32'h77, 1);
        check_eq("idle_cnt", 129'(word_cnt), 129'(10));

        // Backpressure: two words held, the third (last) dropped.
        dut_log.delete(); done_pulses = 0;
        step(1, 0, 0, 0);
        for (int i = 1; i <= 10; i++) step(1, 1, 32'(32'h10 + i), 0);
        check_eq("bp_ovf", 129'(overflow), 129'(1));
        repeat (6) step(1, 0, 0, 1);
        check_eq("bp_nwords", 129'(dut_log.size()), 129'(2));
        if (dut_log.size() == 2) begin
            check_eq("bp_w0", dut_log[0], {1'b0, 32'h11, 32'h12, 32'h13, 32'h14});
            check_eq("bp_w1", dut_log[1], {1'b0, 32'h15, 32'h16, 32'h17, 32'h18});
        end
        check_eq("bp_done_pulses", 129'(done_pulses), 129'(1));
        check_eq("bp_ovf_sticky", 129'(overflow), 129'(1));
        repeat (2) step(0, 0, 0, 1);

        // Push into a full FIFO while the head pops: nothing lost.
        dut_log.delete();
        step(1, 0, 0, 0);
        check_eq("ovf_cleared", 129'(overflow), 129'(0));
        for (int i = 1; i <= 9; i++) step(1, 1, 32'(32'h20 + i), 0);
        step(1, 1, 32'h2A, 1);
        check_eq("fullpop_ovf", 129'(overflow), 129'(0));
        repeat (6) step(1, 0, 0, 1);
        check_eq("fullpop_nwords", 129'(dut_log.size()), 129'(3));
        if (dut_log.size() == 3)
            check_eq("fullpop_w2", dut_log[2], {1'b1, 32'h29, 32'h2A, 32'h0, 32'h0});
        repeat (2) step(0, 0, 0, 1);

        // Gapped input: only odd cycles carry beats.
        dut_log.delete();
        step(1, 0, 0, 1);
        for (int i = 1; i <= 20; i++) step(1, 1'(i % 2), 32'(32'h40 + i), 1);
        repeat (6) step(1, 0, 0, 1);
        check_eq("gap_nwords", 129'(dut_log.size()), 129'(3));
        if (dut_log.size() == 3)
            check_eq("gap_w0", dut_log[0], {1'b0, 32'h41, 32'h43, 32'h45, 32'h47});
        repeat (2) step(0, 0, 0, 1);

        // Abort after five beats: one full word out, partial group discarded.
        dut_log.delete(); done_pulses = 0;
        step(1, 0, 0, 1);
        for (int i = 1; i <= 5; i++) step(1, 1, 32'(32'h50 + i), 1);
        repeat (6) step(0, 0, 0, 1);
        check_eq("abort_nwords", 129'(dut_log.size()), 129'(1));
        if (dut_log.size() == 1)
            check_eq("abort_w0", dut_log[0], {1'b0, 32'h51, 32'h52, 32'h53, 32'h54});
        check_eq("abort_done_pulses", 129'(done_pulses), 129'(1));
        check_eq("abort_cnt", 129'(word_cnt), 129'(5));

        // Randomized traffic across several stages.
        for (int s = 0; s < 12; s++) begin
            step(0, 0, 0, 1);
            step(1, 0, 0, 1);
            for (int c = 0; c < 40; c++) begin
                st  = ($urandom_range(0, 49) != 0);
                tv  = ($urandom_range(0, 2) != 0);
                rdy = ($urandom_range(0, 3) != 0);
                step(st, tv, $urandom, rdy);
            end
        end

        // Reset in the middle of a stage with a word queued.
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        for (int i = 1; i <= 6; i++) step(1, 1, 32'(i), 0);
        check_eq("pre_rst_valid", 129'(m_tvalid), 129'(1));
        do_reset();
        repeat (2) step(0, 0, 0, 1);
        dut_log.delete();
        step(1, 0, 0, 1);
        for (int i = 1; i <= 4; i++) step(1, 1, 32'(32'h60 + i), 1);
        step(1, 0, 0, 1);
        check_eq("post_rst_nwords", 129'(dut_log.size()), 129'(1));
        if (dut_log.size() == 1)
            check_eq("post_rst_w0", dut_log[0], {1'b0, 32'h61, 32'h62, 32'h63, 32'h64});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
